div_arbiter: RTL and testbench

- Shares one SRT4_div instance between NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the divider's start/ready protocol and holds operands stable for the whole operation.
- Returns quotient, remainder and error to the owner over a valid/ready response handshake.
- Sits between client blocks (e.g. ALU issue ports) and the divider.

---
 rtl/div_arbiter.sv | 145 ++++++++++++++
 tb/tb_div_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin front end that shares one divider between NREQ clients.
// Latches the winner's operands, sequences start/ready and returns the result.
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int DRAIN   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_signed,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W-1:0]      resp_q,
  output logic [W-1:0]      resp_r,
  output logic              resp_error,
  output logic              div_start,
  output logic              div_is_signed,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  input  logic              div_ready,
  input  logic              div_error,
  input  logic [W-1:0]      div_q,
  input  logic [W-1:0]      div_r
);

  // state   | meaning
  // S_DRAIN | wait DRAIN cycles so an un-reset divider can finish; requests ignored
  // S_IDLE  | round-robin arbitration, grant latches operands
  // S_ISSUE | one-cycle divider start
  // S_WAIT  | operands held, wait for div_ready or timeout
  // S_RESP  | result offered to the owner until it accepts

  localparam int PW = $clog2(NREQ);
  localparam int DW = $clog2(DRAIN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = 1;

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic          drain_after;

  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign req_ready = (state == S_IDLE && gnt_found) ? (ONE << gnt_idx) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_DRAIN;
      dcnt          <= '0;
      tcnt          <= '0;
      ptr           <= PW'(NREQ - 1);
      owner         <= '0;
      drain_after   <= 1'b0;
      resp_valid    <= '0;
      resp_q        <= '0;
      resp_r        <= '0;
      resp_error    <= 1'b0;
      div_start     <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      div_is_signed <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        S_DRAIN: begin
          if (dcnt == DW'(DRAIN - 1)) begin
            dcnt  <= '0;
            state <= S_IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (gnt_found) begin
            owner         <= gnt_idx;
            div_a         <= req_a[gnt_idx*W +: W];
            div_b         <= req_b[gnt_idx*W +: W];
            div_is_signed <= req_signed[gnt_idx];
            div_start     <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (div_ready) begin
            resp_q     <= div_q;
            resp_r     <= div_r;
            resp_error <= div_error;
            resp_valid <= ONE << owner;
            state      <= S_RESP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // divider state is unknown after a lost op, so drain before reuse
            resp_q      <= '0;
            resp_r      <= '0;
            resp_error  <= 1'b1;
            drain_after <= 1'b1;
            resp_valid  <= ONE << owner;
            state       <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready[owner]) begin
            resp_valid  <= '0;
            ptr         <= owner;
            drain_after <= 1'b0;
            dcnt        <= '0;
            state       <= drain_after ? S_DRAIN : S_IDLE;
          end
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider and a result scoreboard.
module tb_div_arbiter;
  localparam int NREQ = 4, W = 8, DRAIN = 8, TIMEOUT = 15;
  localparam logic [NREQ-1:0] ONE = 1;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_signed, resp_valid, resp_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      resp_q, resp_r, div_a, div_b;
  logic              resp_error, div_start, div_is_signed;
  logic              div_ready = 1'b0, div_error = 1'b0;
  logic [W-1:0]      div_q = 8'hA5, div_r = 8'hA5;

  typedef struct {int idx; logic [7:0] q; logic [7:0] r; logic err;} exp_t;
  exp_t exp_q[$];
  int   grant_log[$];
  int   n_assert = 0, n_fail = 0;
  logic div_dead = 1'b0;
  int   inject_req = 0, inject_done = 0;

  logic       m_busy = 1'b0, m_e;
  int         m_cnt = 0;
  logic [7:0] m_q, m_r;

  div_arbiter #(.NREQ(NREQ), .W(W), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_q(resp_q), .resp_r(resp_r), .resp_error(resp_error),
    .div_start(div_start), .div_is_signed(div_is_signed), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_error(div_error), .div_q(div_q), .div_r(div_r)
  );

  always #5 clock = ~clock;

  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [7:0] q, output logic [7:0] r, output logic err);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; err = 1'b1;
    end else if (s) begin
      q = 8'($signed(a) / $signed(b)); r = 8'($signed(a) % $signed(b)); err = 1'b0;
    end else begin
      q = a / b; r = a % b; err = 1'b0;
    end
  endfunction

  // Divider stand-in: ready 6 cycles after start (2 for b=0), one-cycle pulse.
  always @(negedge clock) begin
    div_ready = 1'b0; div_error = 1'b0; div_q = 8'hA5; div_r = 8'hA5;
    if (inject_req != inject_done) begin
      div_ready = 1'b1; div_q = 8'h55; div_r = 8'h55;
      inject_done = inject_req;
    end
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        div_ready = 1'b1; div_error = m_e; div_q = m_q; div_r = m_r; m_busy = 1'b0;
      end
    end
    if (div_start && !div_dead) begin
      m_busy = 1'b1;
      m_cnt  = (div_b == 8'd0) ? 2 : 6;
      ref_div(div_a, div_b, div_is_signed, m_q, m_r, m_e);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One cycle: sample at negedge, push expectations on grant, compare on handshake.
  task automatic step();
    exp_t ex;
    int   g;
    @(negedge clock);
    if (reset_n) begin
      if (req_ready != '0) begin
        check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
        check("grant_while_busy", 64'(exp_q.size()), 64'd0);
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        ex.idx = g;
        if (div_dead) begin
          ex.q = 8'd0; ex.r = 8'd0; ex.err = 1'b1;
        end else begin
          ref_div(req_a[g*W +: W], req_b[g*W +: W], req_signed[g], ex.q, ex.r, ex.err);
        end
        exp_q.push_back(ex);
        grant_log.push_back(g);
      end
      if ((resp_valid & resp_ready) != '0) begin
        check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          ex = exp_q.pop_front();
          check("sb_owner", 64'(resp_valid), 64'(ONE << ex.idx));
          check("sb_q", 64'(resp_q), 64'(ex.q));
          check("sb_r", 64'(resp_r), 64'(ex.r));
          check("sb_err", 64'(resp_error), 64'(ex.err));
        end
      end
    end
  endtask

  task automatic launch(input int idx, input logic [7:0] a, input logic [7:0] b, input logic s);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_signed[idx]   = s;
    req_valid[idx]    = 1'b1;
  endtask

  task automatic wait_grant(input int idx, input int exp_cyc);
    int cyc = 0;
    bit got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      step();
      if (req_ready[idx]) got = 1'b1;
      else cyc++;
    end
    check("grant_seen", 64'(got), 64'd1);
    if (got) check("grant_cycles", 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic post_grant(input int idx, input logic [7:0] a, input logic [7:0] b, input logic s);
    @(posedge clock); #1;
    req_valid[idx] = 1'b0;
    step();
    check("div_start", 64'(div_start), 64'd1);
    check("div_a", 64'(div_a), 64'(a));
    check("div_b", 64'(div_b), 64'(b));
    check("div_is_signed", 64'(div_is_signed), 64'(s));
  endtask

  task automatic finish_op(input int idx, input logic [7:0] q, input logic [7:0] r,
                           input logic err, input int lat);
    int n = 0;
    do begin
      step();
      n++;
      if (n == 1) check("div_start_pulse", 64'(div_start), 64'd0);
    end while (resp_valid == '0 && n < 100);
    check("resp_latency", 64'(n), 64'(lat));
    check("resp_valid", 64'(resp_valid), 64'(ONE << idx));
    check("resp_q", 64'(resp_q), 64'(q));
    check("resp_r", 64'(resp_r), 64'(r));
    check("resp_error", 64'(resp_error), 64'(err));
    @(posedge clock); #1;
    check("resp_cleared", 64'(resp_valid), 64'd0);
  endtask

  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] q, input logic [7:0] r, input logic err,
                       input int gcyc, input int lat);
    launch(idx, a, b, s);
    wait_grant(idx, gcyc);
    post_grant(idx, a, b, s);
    finish_op(idx, q, r, err, lat);
  endtask

  initial begin
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};
    reset_n = 1'b0; req_valid = '0; req_signed = '0; req_a = '0; req_b = '0; resp_ready = '1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_values", 64'({req_ready, resp_valid, resp_q, resp_r, resp_error,
                               div_start, div_a, div_b, div_is_signed}), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    do_op(0, 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, DRAIN, 7);
    do_op(2, 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 0, 7);
    do_op(1, 8'd5, 8'd0, 1'b0, 8'hFF, 8'd5, 1'b1, 0, 3);
    do_op(3, 8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0, 0, 7);

    // all four requesting continuously
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = 8'(50 + 30 * i);
      req_b[i*W +: W] = 8'(i + 3);
    end
    req_valid = '1;
    for (int k = 0; k < 300 && grant_log.size() < 5; k++) step();
    @(posedge clock); #1;
    req_valid = '0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
    check("rr_count", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", 64'(grant_log[i]), 64'(rr_exp[i]));
    check("rr_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clock); #1;

    // owner stalls its response; non-owner ready bits must not complete it
    resp_ready = 4'b1101;
    launch(1, 8'd77, 8'd5, 1'b0);
    wait_grant(1, 0);
    post_grant(1, 8'd77, 8'd5, 1'b0);
    launch(2, 8'd90, 8'd4, 1'b0);
    for (int k = 0; k < 50 && resp_valid == '0; k++) step();
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_stable", 64'({req_ready, resp_valid, resp_q, resp_r, resp_error}),
            64'({4'b0000, 4'b0010, 8'd15, 8'd2, 1'b0}));
    end
    @(posedge clock); #1;
    resp_ready = '1;
    wait_grant(2, 1);
    post_grant(2, 8'd90, 8'd4, 1'b0);
    finish_op(2, 8'd22, 8'd2, 1'b0, 7);

    // reset while the divider is busy
    launch(0, 8'd9, 8'd2, 1'b0);
    wait_grant(0, 0);
    post_grant(0, 8'd9, 8'd2, 1'b0);
    step();
    step();
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("reset_async", 64'({req_ready, resp_valid, resp_q, resp_r, resp_error,
                              div_start, div_a, div_b, div_is_signed}), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_q.delete();
    inject_req++;
    do_op(3, 8'd60, 8'd7, 1'b0, 8'd8, 8'd4, 1'b0, DRAIN, 7);

    // divider never answers
    div_dead = 1'b1;
    do_op(2, 8'd40, 8'd3, 1'b0, 8'd0, 8'd0, 1'b1, 0, TIMEOUT + 1);
    div_dead = 1'b0;
    do_op(0, 8'd81, 8'd9, 1'b0, 8'd9, 8'd0, 1'b0, DRAIN, 7);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
